// File: rtl/kamus_pkg.sv
// Shared types and constants for the kamus instruction fetch stage.
package kamus_pkg;

  // Canonical no-op (addi x0, x0, 0) shown to ID whenever no word is presented.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // One fetch-buffer slot. The address field is 32 bits wide, so the fetch unit
  // supports PC widths up to 32.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/kamus_fetch_buffer.sv
// In-order fetch ring: slots are allocated at request grant (tail), completed
// by memory responses in order (fill pointer) and consumed by ID (head).
module kamus_fetch_buffer
  import kamus_pkg::*;
#(
  parameter  int unsigned BUF_DEPTH = 2,
  localparam int unsigned PTR_W     = $clog2(BUF_DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic [31:0]      alloc_addr_i,
  input  logic             fill_i,
  input  logic [31:0]      fill_instr_i,
  input  logic             fill_err_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t         ring_q [BUF_DEPTH];
  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [PTR_W-1:0]     fill_q;
  logic [CNT_W-1:0]     count_q;
  logic [BUF_DEPTH-1:0] alloc_hit;
  logic [BUF_DEPTH-1:0] fill_hit;
  logic [BUF_DEPTH-1:0] pop_hit;

  // Per-slot strobes; the three pointers never address the same slot for
  // conflicting operations, except alloc+pop on a full ring (both clear filled).
  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_hit
    assign alloc_hit[gi] = alloc_i && (tail_q == PTR_W'(gi));
    assign fill_hit[gi]  = fill_i  && (fill_q == PTR_W'(gi));
    assign pop_hit[gi]   = pop_i   && (head_q == PTR_W'(gi));
  end

  // Slot contents: allocate claims, fill completes, pop releases; flush empties all.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) ring_q[i] <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (flush_i) begin
          ring_q[i].filled <= 1'b0;
        end else begin
          if (alloc_hit[i]) begin
            ring_q[i].addr   <= alloc_addr_i;
            ring_q[i].err    <= 1'b0;
            ring_q[i].filled <= 1'b0;
          end
          if (fill_hit[i]) begin
            ring_q[i].instr  <= fill_instr_i;
            ring_q[i].err    <= fill_err_i;
            ring_q[i].filled <= 1'b1;
          end
          if (pop_hit[i]) ring_q[i].filled <= 1'b0;
        end
      end
    end
  end

  // Ring pointers and occupancy; pointers wrap naturally since depth is a power of 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PTR_W'(alloc_i);
      fill_q  <= fill_q + PTR_W'(fill_i);
      head_q  <= head_q + PTR_W'(pop_i);
      count_q <= count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
    end
  end

  assign count_o = count_q;
  assign head_o  = ring_q[head_q];

endmodule

// File: rtl/kamus_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests,
// buffers responses and hands words to ID; redirects squash in-flight fetches.
module kamus_fetch_unit
  import kamus_pkg::*;
#(
  parameter int unsigned         PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] BOOT_ADDR = '0,
  parameter int unsigned         BUF_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_addr_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [31:0]         imem_rdata_i,
  input  logic                imem_err_i,
  output logic                instr_valid_o,
  input  logic                id_ready_i,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] instr_addr_o,
  output logic [PC_WIDTH-1:0] next_pc_o,
  output logic                instr_err_o
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [PC_WIDTH-1:0] pc_q;
  logic [CNT_W-1:0]    outstanding_q;
  logic [CNT_W-1:0]    outstanding_next;
  logic [CNT_W-1:0]    discard_q;
  logic [CNT_W-1:0]    count;
  logic [PC_WIDTH-1:0] last_addr_q;
  logic [PC_WIDTH-1:0] last_next_q;
  logic [PC_WIDTH-1:0] head_addr;
  fetch_entry_t        head;
  logic                pop;
  logic                room;
  logic                fire;
  logic                resp;
  logic                fill;

  assign head_addr = head.addr[PC_WIDTH-1:0];
  assign pop       = head.filled && id_ready_i;
  // A slot being popped this cycle can be reallocated at once, which keeps a
  // zero-wait memory streaming one word per cycle. The outstanding guard stops
  // the counter wrapping when redirects pile discards on top of new fetches.
  assign room       = (count < CNT_W'(BUF_DEPTH)) || pop;
  assign imem_req_o = !rst_i && room && !redirect_i && (outstanding_q != '1);
  assign imem_addr_o = pc_q;
  assign fire       = imem_req_o && imem_gnt_i;
  // Responses with nothing outstanding are stray and ignored.
  assign resp       = imem_rvalid_i && (outstanding_q != '0);
  assign fill       = resp && (discard_q == '0) && !redirect_i;
  assign outstanding_next = outstanding_q + CNT_W'(fire) - CNT_W'(resp);

  kamus_fetch_buffer #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .alloc_i     (fire),
    .alloc_addr_i(32'(pc_q)),
    .fill_i      (fill),
    .fill_instr_i(imem_rdata_i),
    .fill_err_i  (imem_err_i),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  // PC: redirect target (word aligned) wins, otherwise advance on each grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)           pc_q <= BOOT_ADDR;
    else if (redirect_i) pc_q <= {redirect_addr_i[PC_WIDTH-1:2], 2'b00};
    else if (fire)       pc_q <= pc_q + PC_WIDTH'(4);
  end

  // In-flight accounting: on redirect every fetch still owed becomes a discard.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_next;
      if (redirect_i)                      discard_q <= outstanding_next;
      else if (resp && discard_q != '0)    discard_q <= discard_q - CNT_W'(1);
    end
  end

  // Remember the last consumed address so the address outputs hold when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_addr_q <= '0;
      last_next_q <= '0;
    end else if (pop) begin
      last_addr_q <= head_addr;
      last_next_q <= head_addr + PC_WIDTH'(4);
    end
  end

  assign instr_valid_o = head.filled;
  assign instr_o       = head.filled ? head.instr : INSTR_NOP;
  assign instr_addr_o  = head.filled ? head_addr : last_addr_q;
  assign next_pc_o     = head.filled ? head_addr + PC_WIDTH'(4) : last_next_q;
  assign instr_err_o   = head.filled && head.err;

endmodule

// File: tb/tb_kamus_fetch_unit.sv
// Directed bench for kamus_fetch_unit with a small in-order instruction memory.
module tb_kamus_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        merr;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] iaddr;
  logic [31:0] npc;
  logic        ierr;

  int checks = 0;
  int errors = 0;

  logic        hold = 1'b0;
  logic        stray = 1'b0;
  logic        from_q = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] pend [$];

  always #5 clk = ~clk;

  kamus_fetch_unit #(
    .PC_WIDTH (32),
    .BOOT_ADDR(32'h0000_0080),
    .BUF_DEPTH(2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .imem_req_o     (req),
    .imem_addr_o    (addr),
    .imem_gnt_i     (gnt),
    .imem_rvalid_i  (rvalid),
    .imem_rdata_i   (rdata),
    .imem_err_i     (merr),
    .instr_valid_o  (valid),
    .id_ready_i     (ready),
    .instr_o        (instr),
    .instr_addr_o   (iaddr),
    .next_pc_o      (npc),
    .instr_err_o    (ierr)
  );

  function automatic logic [31:0] word_of(logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive this cycle's memory response, then settle to the falling edge.
  task automatic mid();
    from_q = 1'b0;
    rvalid = 1'b0;
    rdata  = 32'h0;
    merr   = 1'b0;
    if (rst) begin
      pend.delete();
    end else if (stray) begin
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
    end else if (!hold && pend.size() > 0) begin
      rvalid = 1'b1;
      rdata  = word_of(pend[0]);
      merr   = (pend[0] == err_addr);
      from_q = 1'b1;
    end
    @(negedge clk);
  endtask

  // Record this cycle's handshakes, then move to just after the next rising edge.
  task automatic tick();
    if (rvalid && from_q) void'(pend.pop_front());
    if (req && gnt) pend.push_back(addr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; gnt = 1'b1; ready = 1'b1;
    hold = 1'b0; stray = 1'b0; err_addr = 32'hFFFF_FFFF;
    mid(); tick(); mid(); tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_req"},   req,   0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_iaddr"}, iaddr, 0);
    chk({tag, "_npc"},   npc,   0);
    chk({tag, "_ierr"},  ierr,  0);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_addr = 32'h0; gnt = 1'b1; ready = 1'b1;
    rvalid = 1'b0; rdata = 32'h0; merr = 1'b0;

    // Reset state
    mid(); chk_reset("rst");
    tick(); mid(); tick();
    rst = 1'b0;

    // 1: zero-wait streaming from BOOT_ADDR
    mid(); chk("t1_c0_req", req, 1); chk("t1_c0_addr", addr, 32'h80); tick();
    mid(); chk("t1_c1_addr", addr, 32'h84); chk("t1_c1_valid", valid, 0); tick();
    mid();
    chk("t1_c2_addr", addr, 32'h88);
    chk("t1_c2_valid", valid, 1);
    chk("t1_c2_iaddr", iaddr, 32'h80);
    chk("t1_c2_npc", npc, 32'h84);
    chk("t1_c2_instr", instr, 32'hC0DE_0080);
    tick();

    // 2: ID stall for 6 cycles, then release
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("t2_stall_req", req, 0);
      chk("t2_stall_valid", valid, 1);
      chk("t2_stall_iaddr", iaddr, 32'h84);
      chk("t2_stall_instr", instr, 32'hC0DE_0084);
      tick();
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t2_rel_valid", valid, 1);
      chk("t2_rel_iaddr", iaddr, 32'h84 + 32'(4 * i));
      chk("t2_rel_instr", instr, word_of(32'h84 + 32'(4 * i)));
      tick();
    end

    // 3: stray response after reset, then gnt withheld 3 cycles
    do_reset();
    stray = 1'b1;
    mid(); chk("t3_c0_addr", addr, 32'h80); tick();
    stray = 1'b0; gnt = 1'b0;
    mid(); chk("t3_c1_valid", valid, 0); chk("t3_c1_addr", addr, 32'h84); tick();
    mid();
    chk("t3_c2_valid", valid, 1);
    chk("t3_c2_instr", instr, 32'hC0DE_0080);
    chk("t3_c2_addr", addr, 32'h84);
    chk("t3_c2_req", req, 1);
    tick();
    mid(); chk("t3_c3_addr", addr, 32'h84); chk("t3_c3_valid", valid, 0); tick();
    gnt = 1'b1;
    mid(); chk("t3_c4_addr", addr, 32'h84); tick();
    mid(); chk("t3_c5_addr", addr, 32'h88); chk("t3_c5_valid", valid, 0); tick();
    mid(); chk("t3_c6_valid", valid, 1); chk("t3_c6_iaddr", iaddr, 32'h84); tick();

    // 4: redirect to 0x203 with two fetches outstanding
    do_reset();
    hold = 1'b1;
    mid(); tick();
    mid(); chk("t4_c1_addr", addr, 32'h84); tick();
    redirect = 1'b1; redirect_addr = 32'h203;
    mid(); chk("t4_c2_req", req, 0); tick();
    redirect = 1'b0; hold = 1'b0;
    mid();
    chk("t4_c3_addr", addr, 32'h200);
    chk("t4_c3_req", req, 1);
    chk("t4_c3_valid", valid, 0);
    tick();
    mid(); chk("t4_c4_valid", valid, 0); chk("t4_c4_addr", addr, 32'h204); tick();
    mid(); chk("t4_c5_valid", valid, 0); tick();
    mid();
    chk("t4_c6_valid", valid, 1);
    chk("t4_c6_iaddr", iaddr, 32'h200);
    chk("t4_c6_instr", instr, 32'hC0DE_0200);
    chk("t4_c6_npc", npc, 32'h204);
    tick();

    // 5: redirect coincident with gnt and rvalid
    do_reset();
    hold = 1'b1;
    mid(); tick();
    mid(); tick();
    hold = 1'b0; redirect = 1'b1; redirect_addr = 32'h300;
    mid(); chk("t5_c2_req", req, 0); chk("t5_c2_valid", valid, 0); tick();
    redirect = 1'b0;
    mid(); chk("t5_c3_addr", addr, 32'h300); chk("t5_c3_valid", valid, 0); tick();
    mid(); chk("t5_c4_valid", valid, 0); tick();
    mid();
    chk("t5_c5_valid", valid, 1);
    chk("t5_c5_iaddr", iaddr, 32'h300);
    chk("t5_c5_instr", instr, 32'hC0DE_0300);
    tick();

    // 6: access fault on 0x88, then reset mid-stream
    do_reset();
    err_addr = 32'h88;
    mid(); tick();
    mid(); tick();
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t6_valid", valid, 1);
      chk("t6_iaddr", iaddr, 32'h80 + 32'(4 * k));
      chk("t6_ierr", ierr, (k == 2) ? 32'd1 : 32'd0);
      tick();
    end
    rst = 1'b1;
    mid(); chk_reset("t6_rst");
    tick();
    rst = 1'b0;
    mid(); chk("t6_restart_addr", addr, 32'h80); chk("t6_restart_req", req, 1); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
